// File: rtl/complex_nr_mult_pipe.sv
// complex_nr_mult_pipe
//   Fully pipelined signed complex multiplier / multiply-accumulator.
//   One beat per clock. Three register stages: operands, partial products,
//   then combine/accumulate into the result register.
//
// Ports
//   clk, sw_rst             clock, synchronous active-high reset
//   op_val / op_rdy         operand handshake; op_rdy = !res_val || res_rdy
//   op_conj                 1: op_1 * conj(op_2)
//   op_acc, op_last         accumulation burst membership / burst close
//   op_{1,2}_{re,im}        OP_W-bit two's complement operand components
//   res_val / res_rdy       result handshake
//   res_re, res_im          RES_W-bit signed result components
//   res_sat                 closing result of a burst saturated somewhere
module complex_nr_mult_pipe #(
  parameter int OP_W  = 8,
  parameter int RES_W = 2*OP_W+1
) (
  input  logic             clk,
  input  logic             sw_rst,
  input  logic             op_val,
  output logic             op_rdy,
  input  logic             op_conj,
  input  logic             op_acc,
  input  logic             op_last,
  input  logic [OP_W-1:0]  op_1_re,
  input  logic [OP_W-1:0]  op_1_im,
  input  logic [OP_W-1:0]  op_2_re,
  input  logic [OP_W-1:0]  op_2_im,
  output logic             res_val,
  input  logic             res_rdy,
  output logic [RES_W-1:0] res_re,
  output logic [RES_W-1:0] res_im,
  output logic             res_sat
);
  localparam int PW     = 2*OP_W;
  localparam int STAGES = 2;  // stages ahead of the result register

  typedef struct packed { logic conj; logic acc; logic last; } flags_t;
  typedef struct packed { logic [OP_W-1:0] ar, ai, br, bi; } ops_t;
  typedef struct packed { logic [PW-1:0] rr, ii, ri, ir; } prod_t;

  logic              w_en;
  logic [STAGES:1]   r_vld_pipe;
  ops_t              r_s1_ops;
  flags_t            r_s1_flg;
  prod_t             r_s2_prod;
  flags_t            r_s2_flg;
  logic [RES_W-1:0]  r_acc_re, r_acc_im;
  logic              r_acc_sat;

  logic [RES_W-1:0]  w_rr, w_ii, w_ri, w_ir, w_re, w_im;
  logic [RES_W:0]    w_sum_re, w_sum_im;
  logic [RES_W-1:0]  w_acc_re, w_acc_im;
  logic              w_ovf;

  // Global stall: everything advances only when the result slot frees up.
  assign op_rdy = !res_val || res_rdy;
  assign w_en   = op_rdy;

  function automatic logic [PW-1:0] f_mul(input logic [OP_W-1:0] a, input logic [OP_W-1:0] b);
    logic signed [PW-1:0] sa, sb;
    sa = PW'($signed(a));
    sb = PW'($signed(b));
    return PW'(sa * sb);
  endfunction

  function automatic logic [RES_W-1:0] f_sx(input logic [PW-1:0] p);
    return RES_W'($signed(p));
  endfunction

  // One guard bit above RES_W: top two bits disagreeing means overflow.
  function automatic logic [RES_W-1:0] f_sat(input logic [RES_W:0] v);
    if (v[RES_W] != v[RES_W-1])
      return v[RES_W] ? {1'b1, {(RES_W-1){1'b0}}} : {1'b0, {(RES_W-1){1'b1}}};
    return v[RES_W-1:0];
  endfunction

  // S3 combine; a single product always fits RES_W.
  always_comb begin
    w_rr = f_sx(r_s2_prod.rr);
    w_ii = f_sx(r_s2_prod.ii);
    w_ri = f_sx(r_s2_prod.ri);
    w_ir = f_sx(r_s2_prod.ir);
    w_re = r_s2_flg.conj ? (w_rr + w_ii) : (w_rr - w_ii);
    w_im = r_s2_flg.conj ? (w_ir - w_ri) : (w_ri + w_ir);
    w_sum_re = {r_acc_re[RES_W-1], r_acc_re} + {w_re[RES_W-1], w_re};
    w_sum_im = {r_acc_im[RES_W-1], r_acc_im} + {w_im[RES_W-1], w_im};
    w_acc_re = f_sat(w_sum_re);
    w_acc_im = f_sat(w_sum_im);
    w_ovf    = (w_sum_re[RES_W] ^ w_sum_re[RES_W-1]) |
               (w_sum_im[RES_W] ^ w_sum_im[RES_W-1]);
  end

  always_ff @(posedge clk) begin
    if (sw_rst) begin
      r_vld_pipe <= '0;
      r_s1_ops   <= '0;
      r_s1_flg   <= '0;
      r_s2_prod  <= '0;
      r_s2_flg   <= '0;
      r_acc_re   <= '0;
      r_acc_im   <= '0;
      r_acc_sat  <= 1'b0;
      res_val    <= 1'b0;
      res_re     <= '0;
      res_im     <= '0;
      res_sat    <= 1'b0;
    end else if (w_en) begin
      r_vld_pipe <= {r_vld_pipe[1], op_val};
      r_s1_ops   <= {op_1_re, op_1_im, op_2_re, op_2_im};
      r_s1_flg   <= {op_conj, op_acc, op_last};
      r_s2_prod  <= {f_mul(r_s1_ops.ar, r_s1_ops.br), f_mul(r_s1_ops.ai, r_s1_ops.bi),
                     f_mul(r_s1_ops.ar, r_s1_ops.bi), f_mul(r_s1_ops.ai, r_s1_ops.br)};
      r_s2_flg   <= r_s1_flg;
      // Mid-burst beats only feed the accumulator and emit nothing.
      res_val    <= r_vld_pipe[2] && (!r_s2_flg.acc || r_s2_flg.last);
      if (r_vld_pipe[2]) begin
        if (!r_s2_flg.acc) begin
          res_re  <= w_re;
          res_im  <= w_im;
          res_sat <= 1'b0;
        end else if (!r_s2_flg.last) begin
          r_acc_re  <= w_acc_re;
          r_acc_im  <= w_acc_im;
          r_acc_sat <= r_acc_sat | w_ovf;
        end else begin
          res_re    <= w_acc_re;
          res_im    <= w_acc_im;
          res_sat   <= r_acc_sat | w_ovf;
          r_acc_re  <= '0;
          r_acc_im  <= '0;
          r_acc_sat <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_complex_nr_mult_pipe.sv
// Bench for complex_nr_mult_pipe: directed single-beat table with exact
// latency, hand sequences for bursts/saturation/stall/reset, then random
// traffic against an integer-arithmetic reference model with a result queue.
module tb_complex_nr_mult_pipe;
  localparam int OP_W  = 8;
  localparam int RES_W = 2*OP_W+1;
  localparam int RMAX  = (1 << (RES_W-1)) - 1;
  localparam int RMIN  = -(1 << (RES_W-1));

  logic clk = 1'b0;
  logic sw_rst, op_val, op_rdy, op_conj, op_acc, op_last, res_val, res_rdy, res_sat;
  logic [OP_W-1:0]  op_1_re, op_1_im, op_2_re, op_2_im;
  logic [RES_W-1:0] res_re, res_im;

  always #5 clk = ~clk;

  complex_nr_mult_pipe #(.OP_W(OP_W), .RES_W(RES_W)) dut (
    .clk(clk), .sw_rst(sw_rst), .op_val(op_val), .op_rdy(op_rdy),
    .op_conj(op_conj), .op_acc(op_acc), .op_last(op_last),
    .op_1_re(op_1_re), .op_1_im(op_1_im), .op_2_re(op_2_re), .op_2_im(op_2_im),
    .res_val(res_val), .res_rdy(res_rdy), .res_re(res_re), .res_im(res_im),
    .res_sat(res_sat));

  typedef struct { int ar, ai, br, bi; bit conj; int ere, eim; } vec_t;
  typedef struct { int re, im; bit sat; } res_t;

  int   errs = 0, checks = 0;
  res_t q[$];
  int   m_acc_re = 0, m_acc_im = 0;
  bit   m_sat = 0;
  int   stall_left = 0;

  function automatic int sres(input logic [RES_W-1:0] v);
    return int'($signed(v));
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int clamp(input int v, inout bit s);
    if (v > RMAX) begin s = 1; return RMAX; end
    if (v < RMIN) begin s = 1; return RMIN; end
    return v;
  endfunction

  // Reference model: complex product, then burst accumulation with clamping.
  task automatic model(input int ar, ai, br, bi, input bit c, a, l);
    int pre, pim;
    res_t r;
    pre = c ? ar*br + ai*bi : ar*br - ai*bi;
    pim = c ? ai*br - ar*bi : ar*bi + ai*br;
    if (!a) begin
      r.re = pre; r.im = pim; r.sat = 0; q.push_back(r);
    end else begin
      m_acc_re = clamp(m_acc_re + pre, m_sat);
      m_acc_im = clamp(m_acc_im + pim, m_sat);
      if (l) begin
        r.re = m_acc_re; r.im = m_acc_im; r.sat = m_sat; q.push_back(r);
        m_acc_re = 0; m_acc_im = 0; m_sat = 0;
      end
    end
  endtask

  // One clock of traffic: drive at negedge, then check handshake and results.
  task automatic step(input bit v, c, a, l, input int ar, ai, br, bi, output bit acc);
    res_t e;
    @(negedge clk);
    op_val = v; op_conj = c; op_acc = a; op_last = l;
    op_1_re = ar[OP_W-1:0]; op_1_im = ai[OP_W-1:0];
    op_2_re = br[OP_W-1:0]; op_2_im = bi[OP_W-1:0];
    res_rdy = (stall_left == 0);
    if (stall_left > 0) stall_left--;
    #1;
    chk("op_rdy", int'(op_rdy), int'(!res_val || res_rdy));
    if (res_val && res_rdy) begin
      if (q.size() == 0) chk("unexpected_res_val", 1, 0);
      else begin
        e = q.pop_front();
        chk("res_re", sres(res_re), e.re);
        chk("res_im", sres(res_im), e.im);
        chk("res_sat", int'(res_sat), int'(e.sat));
      end
    end
    acc = op_val && op_rdy;
    if (acc) model(ar, ai, br, bi, c, a, l);
  endtask

  // Hold a beat until accepted, with a bound.
  task automatic send(input bit c, a, l, input int ar, ai, br, bi);
    bit ok;
    ok = 0;
    for (int t = 0; t < 40 && !ok; t++) step(1, c, a, l, ar, ai, br, bi, ok);
    if (!ok) chk("send_timeout", 0, 1);
  endtask

  task automatic idle(input int n);
    bit ok;
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, ok);
  endtask

  task automatic drain();
    for (int t = 0; t < 60 && q.size() != 0; t++) idle(1);
    chk("drain_queue_empty", q.size(), 0);
    idle(2);
  endtask

  task automatic do_reset();
    @(negedge clk);
    sw_rst = 1; op_val = 0; res_rdy = 1;
    @(negedge clk);
    chk("rst_res_val", int'(res_val), 0);
    chk("rst_res_re", sres(res_re), 0);
    chk("rst_res_sat", int'(res_sat), 0);
    sw_rst = 0;
    q.delete();
    m_acc_re = 0; m_acc_im = 0; m_sat = 0;
  endtask

  vec_t tbl[6];

  initial begin
    bit ok;
    tbl[0] = '{2, 3, 4, 2, 0, 2, 16};
    tbl[1] = '{2, 3, 4, 2, 1, 14, 8};
    tbl[2] = '{-128, -128, -128, -128, 0, 0, 32768};
    tbl[3] = '{-128, -128, -128, -128, 1, 32768, 0};
    tbl[4] = '{127, 127, -128, 127, 0, -32385, -127};
    tbl[5] = '{-1, 0, 5, -7, 0, -5, 7};

    sw_rst = 1; op_val = 0; op_conj = 0; op_acc = 0; op_last = 0; res_rdy = 1;
    op_1_re = '0; op_1_im = '0; op_2_re = '0; op_2_im = '0;
    repeat (3) @(negedge clk);
    chk("reset_res_val", int'(res_val), 0);
    chk("reset_res_im", sres(res_im), 0);
    chk("reset_op_rdy", int'(op_rdy), 1);
    sw_rst = 0;

    // Directed single beats: result must appear exactly 3 cycles after accept.
    foreach (tbl[i]) begin
      @(negedge clk);
      op_val = 1; op_acc = 0; op_last = 0; op_conj = tbl[i].conj; res_rdy = 1;
      op_1_re = tbl[i].ar[OP_W-1:0]; op_1_im = tbl[i].ai[OP_W-1:0];
      op_2_re = tbl[i].br[OP_W-1:0]; op_2_im = tbl[i].bi[OP_W-1:0];
      @(negedge clk); op_val = 0;
      @(negedge clk);
      chk($sformatf("tbl%0d_early_val", i), int'(res_val), 0);
      @(negedge clk);
      chk($sformatf("tbl%0d_val", i), int'(res_val), 1);
      chk($sformatf("tbl%0d_re", i), sres(res_re), tbl[i].ere);
      chk($sformatf("tbl%0d_im", i), sres(res_im), tbl[i].eim);
      chk($sformatf("tbl%0d_sat", i), int'(res_sat), 0);
    end
    idle(2);

    // Burst 1+1j squared, then 2*3 closing: single result 6+2j.
    send(0, 1, 0, 1, 1, 1, 1);
    send(0, 0, 1, 5, 5, 5, 5);  // acc=0 beat interleaved, last ignored
    send(0, 1, 1, 2, 0, 3, 0);
    drain();

    // Saturating burst, then a plain beat with res_sat cleared.
    send(0, 1, 0, -128, -128, -128, -128);
    send(0, 1, 0, -128, -128, -128, -128);
    send(0, 1, 1, -128, -128, -128, -128);
    send(0, 0, 0, 1, 0, 1, 0);
    drain();

    // Ten back-to-back beats with a 4-cycle sink stall mid-stream.
    for (int i = 0; i < 10; i++) begin
      if (i == 4) stall_left = 4;
      send(i[0], 0, 0, i, -i, 3, i+1);
    end
    drain();

    // Reset mid-stream with an open burst and beats in flight.
    send(0, 1, 0, 50, 50, 50, 50);
    send(0, 0, 0, 7, 1, 2, 3);
    send(1, 0, 0, 4, 4, 4, 4);
    do_reset();
    send(0, 0, 0, 3, 4, 1, 2);
    send(0, 1, 1, 1, 0, 1, 0);  // burst-close must not include pre-reset sum
    drain();

    // Random traffic with back-pressure, extremes biased for saturation.
    for (int n = 0; n < 600; n++) begin
      int o[4];
      foreach (o[k]) o[k] = ($urandom % 4 == 0) ? (($urandom % 2) ? 127 : -128)
                                                : int'($urandom_range(0, 255)) - 128;
      if (stall_left == 0 && $urandom % 5 == 0) stall_left = $urandom_range(1, 3);
      step(($urandom % 4) != 0, $urandom % 2, ($urandom % 3) == 0, ($urandom % 3) == 0,
           o[0], o[1], o[2], o[3], ok);
    end
    stall_left = 0;
    drain();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
